// File: rtl/rs_alu_issue_pkg.sv
// ============================================================================
// Module   : rs_alu_issue_pkg
// Brief    : Shared widths, ALU opcode codes, entry record and CDB tag-match
//            helper for the ALU reservation station.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_alu_issue_pkg;

    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd3;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd4;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd8;
    localparam logic [OP_W-1:0] OP_OR    = 6'd9;
    localparam logic [OP_W-1:0] OP_AND   = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd11;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd12;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd13;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd15;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd16;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd17;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd18;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd19;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd20;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd21;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd22;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd23;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd24;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd25;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd26;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [ROB_W-1:0]  rob_name;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_sgn;
        logic [ROB_W-1:0]  qj;
        logic              qk_sgn;
        logic [ROB_W-1:0]  qk;
    } rs_entry_t;

    // True when a still-pending operand is produced by the given broadcast.
    function automatic logic cdb_match(input logic             pend,
                                       input logic [ROB_W-1:0] q,
                                       input logic             cdb_sgn,
                                       input logic [ROB_W-1:0] cdb_tag);
        return pend & cdb_sgn & (q == cdb_tag);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_alu_issue_if.sv
// ============================================================================
// Module   : rs_alu_issue_if
// Brief    : Dispatch, CDB snoop and ALU issue bundle of the ALU reservation
//            station; master drives dispatch/CDB, slave is the station.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs_alu_issue_if
    import rs_alu_issue_pkg::*;
    ();

    logic              DP_sgn;
    logic [OP_W-1:0]   DP_opcode;
    logic [ROB_W-1:0]  DP_ROB_name;
    logic              DP_Qj_sgn;
    logic              DP_Qk_sgn;
    logic [ROB_W-1:0]  DP_Qj;
    logic [ROB_W-1:0]  DP_Qk;
    logic [DATA_W-1:0] DP_Vj;
    logic [DATA_W-1:0] DP_Vk;
    logic              RS_full;

    logic              ALU_CDB_sgn;
    logic [ROB_W-1:0]  ALU_CDB_ROB_name;
    logic [DATA_W-1:0] ALU_CDB_result;
    logic              LSB_CDB_sgn;
    logic [ROB_W-1:0]  LSB_CDB_ROB_name;
    logic [DATA_W-1:0] LSB_CDB_result;

    logic              ALU_sgn;
    logic [OP_W-1:0]   ALU_opcode;
    logic [ROB_W-1:0]  ALU_ROB_name;
    logic [DATA_W-1:0] ALU_lhs;
    logic [DATA_W-1:0] ALU_rhs;

    modport master (
        output DP_sgn, DP_opcode, DP_ROB_name, DP_Qj_sgn, DP_Qk_sgn,
               DP_Qj, DP_Qk, DP_Vj, DP_Vk,
               ALU_CDB_sgn, ALU_CDB_ROB_name, ALU_CDB_result,
               LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result,
        input  RS_full, ALU_sgn, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs
    );

    modport slave (
        input  DP_sgn, DP_opcode, DP_ROB_name, DP_Qj_sgn, DP_Qk_sgn,
               DP_Qj, DP_Qk, DP_Vj, DP_Vk,
               ALU_CDB_sgn, ALU_CDB_ROB_name, ALU_CDB_result,
               LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result,
        output RS_full, ALU_sgn, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs
    );

endinterface

`default_nettype wire

// File: rtl/rs_alu_issue_prio_enc.sv
// ============================================================================
// Module   : rs_prio_enc
// Brief    : Lowest-set-bit priority encoder returning {found, index}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_alu_issue.sv
// ============================================================================
// Module   : rs_alu_issue
// Brief    : Integer ALU reservation station: holds dispatched ops until both
//            operands arrive via ALU/LSB CDB, issues one ready op per cycle.
// Config   : RS_WAKEUP_ISSUE_EN - an op woken this cycle may issue this cycle
//            with the CDB value forwarded (default: wakeup lands first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_alu_issue
    import rs_alu_issue_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clr,
    rs_alu_issue_if.slave bus
);

    localparam int CNT_W = IDX_W + 1;

    rs_entry_t         r_entry [RS_SIZE];
    logic [CNT_W-1:0]  r_count;
    logic              r_alu_sgn;
    logic [OP_W-1:0]   r_alu_opcode;
    logic [ROB_W-1:0]  r_alu_rob_name;
    logic [DATA_W-1:0] r_alu_lhs;
    logic [DATA_W-1:0] r_alu_rhs;

    logic [RS_SIZE-1:0] w_free;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_j_hit;
    logic [RS_SIZE-1:0] w_k_hit;
    logic [DATA_W-1:0]  w_j_val [RS_SIZE];
    logic [DATA_W-1:0]  w_k_val [RS_SIZE];

    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_dp_take;
    rs_entry_t          w_dp_entry;

    // Per-slot wakeup: w_*_val is the operand as it will look after this edge.
    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic w_j_alu, w_j_lsb, w_k_alu, w_k_lsb;
            logic w_j_pend, w_k_pend;

            assign w_j_pend = r_entry[gi].valid & r_entry[gi].qj_sgn;
            assign w_k_pend = r_entry[gi].valid & r_entry[gi].qk_sgn;
            assign w_j_alu  = cdb_match(w_j_pend, r_entry[gi].qj, bus.ALU_CDB_sgn, bus.ALU_CDB_ROB_name);
            assign w_j_lsb  = cdb_match(w_j_pend, r_entry[gi].qj, bus.LSB_CDB_sgn, bus.LSB_CDB_ROB_name);
            assign w_k_alu  = cdb_match(w_k_pend, r_entry[gi].qk, bus.ALU_CDB_sgn, bus.ALU_CDB_ROB_name);
            assign w_k_lsb  = cdb_match(w_k_pend, r_entry[gi].qk, bus.LSB_CDB_sgn, bus.LSB_CDB_ROB_name);

            assign w_j_hit[gi] = w_j_alu | w_j_lsb;
            assign w_k_hit[gi] = w_k_alu | w_k_lsb;
            assign w_j_val[gi] = w_j_alu ? bus.ALU_CDB_result :
                                 w_j_lsb ? bus.LSB_CDB_result : r_entry[gi].vj;
            assign w_k_val[gi] = w_k_alu ? bus.ALU_CDB_result :
                                 w_k_lsb ? bus.LSB_CDB_result : r_entry[gi].vk;
            assign w_free[gi]  = ~r_entry[gi].valid;
`ifdef RS_WAKEUP_ISSUE_EN
            assign w_ready[gi] = r_entry[gi].valid
                               & (~r_entry[gi].qj_sgn | w_j_hit[gi])
                               & (~r_entry[gi].qk_sgn | w_k_hit[gi]);
`else
            assign w_ready[gi] = r_entry[gi].valid & ~r_entry[gi].qj_sgn & ~r_entry[gi].qk_sgn;
`endif
        end
    endgenerate

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
        .req   (w_free),
        .found (w_free_found),
        .idx   (w_free_idx)
    );

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(IDX_W)) u_sel_enc (
        .req   (w_ready),
        .found (w_sel_found),
        .idx   (w_sel_idx)
    );

    // Dispatch-time capture of an operand broadcast in the same cycle.
    always_comb begin
        logic w_dj_alu, w_dj_lsb, w_dk_alu, w_dk_lsb;
        w_dj_alu = cdb_match(bus.DP_Qj_sgn, bus.DP_Qj, bus.ALU_CDB_sgn, bus.ALU_CDB_ROB_name);
        w_dj_lsb = cdb_match(bus.DP_Qj_sgn, bus.DP_Qj, bus.LSB_CDB_sgn, bus.LSB_CDB_ROB_name);
        w_dk_alu = cdb_match(bus.DP_Qk_sgn, bus.DP_Qk, bus.ALU_CDB_sgn, bus.ALU_CDB_ROB_name);
        w_dk_lsb = cdb_match(bus.DP_Qk_sgn, bus.DP_Qk, bus.LSB_CDB_sgn, bus.LSB_CDB_ROB_name);

        w_dp_entry          = '0;
        w_dp_entry.valid    = 1'b1;
        w_dp_entry.opcode   = bus.DP_opcode;
        w_dp_entry.rob_name = bus.DP_ROB_name;
        w_dp_entry.qj       = bus.DP_Qj;
        w_dp_entry.qk       = bus.DP_Qk;
        w_dp_entry.qj_sgn   = bus.DP_Qj_sgn & ~(w_dj_alu | w_dj_lsb);
        w_dp_entry.qk_sgn   = bus.DP_Qk_sgn & ~(w_dk_alu | w_dk_lsb);
        w_dp_entry.vj       = w_dj_alu ? bus.ALU_CDB_result :
                              w_dj_lsb ? bus.LSB_CDB_result : bus.DP_Vj;
        w_dp_entry.vk       = w_dk_alu ? bus.ALU_CDB_result :
                              w_dk_lsb ? bus.LSB_CDB_result : bus.DP_Vk;
    end

    // A dispatch with no free slot is dropped; RS_full slack makes this an upstream error.
    assign w_dp_take = bus.DP_sgn & w_free_found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i] <= '0;
            end
            r_count        <= '0;
            r_alu_sgn      <= 1'b0;
            r_alu_opcode   <= '0;
            r_alu_rob_name <= '0;
            r_alu_lhs      <= '0;
            r_alu_rhs      <= '0;
        end else if (!rdy) begin
            r_alu_sgn <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i].valid <= 1'b0;
            end
            r_count   <= '0;
            r_alu_sgn <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_j_hit[i]) begin
                    r_entry[i].vj     <= w_j_val[i];
                    r_entry[i].qj_sgn <= 1'b0;
                end
                if (w_k_hit[i]) begin
                    r_entry[i].vk     <= w_k_val[i];
                    r_entry[i].qk_sgn <= 1'b0;
                end
                if (w_sel_found && (w_sel_idx == IDX_W'(i))) begin
                    r_entry[i].valid <= 1'b0;
                end
                // Free slot and selected slot are disjoint, so no overlap here.
                if (w_dp_take && (w_free_idx == IDX_W'(i))) begin
                    r_entry[i] <= w_dp_entry;
                end
            end
            r_count   <= r_count + CNT_W'(w_dp_take) - CNT_W'(w_sel_found);
            r_alu_sgn <= w_sel_found;
            if (w_sel_found) begin
                r_alu_opcode   <= r_entry[w_sel_idx].opcode;
                r_alu_rob_name <= r_entry[w_sel_idx].rob_name;
                r_alu_lhs      <= w_j_val[w_sel_idx];
                r_alu_rhs      <= w_k_val[w_sel_idx];
            end
        end
    end

    assign bus.RS_full      = (r_count >= CNT_W'(RS_SIZE - 1));
    assign bus.ALU_sgn      = r_alu_sgn;
    assign bus.ALU_opcode   = r_alu_opcode;
    assign bus.ALU_ROB_name = r_alu_rob_name;
    assign bus.ALU_lhs      = r_alu_lhs;
    assign bus.ALU_rhs      = r_alu_rhs;

endmodule

`default_nettype wire

// File: tb/tb_rs_alu_issue.sv
// ============================================================================
// Module   : tb_rs_alu_issue
// Brief    : Directed, table-driven bench for rs_alu_issue plus hand-written
//            full/flush/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_alu_issue;
    import rs_alu_issue_pkg::*;

`ifdef RS_WAKEUP_ISSUE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic        rdy;
        logic        dp;
        logic [5:0]  op;
        logic [3:0]  name;
        logic        qjs;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic        qks;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic        acdb;
        logic [3:0]  atag;
        logic [31:0] ares;
        logic        lcdb;
        logic [3:0]  ltag;
        logic [31:0] lres;
        logic        e_sgn;
        logic [5:0]  e_op;
        logic [3:0]  e_name;
        logic [31:0] e_lhs;
        logic [31:0] e_rhs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    rs_alu_issue_if bus ();

    rs_alu_issue #(.RS_SIZE(16), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v_idle();
        vec_t v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_dp(input logic [5:0] op, input logic [3:0] name,
                                  input logic qjs, input logic [3:0] qj, input logic [31:0] vj,
                                  input logic qks, input logic [3:0] qk, input logic [31:0] vk);
        vec_t v = v_idle();
        v.dp = 1'b1; v.op = op; v.name = name;
        v.qjs = qjs; v.qj = qj; v.vj = vj;
        v.qks = qks; v.qk = qk; v.vk = vk;
        return v;
    endfunction

    function automatic vec_t w_acdb(input vec_t vi, input logic [3:0] tag, input logic [31:0] res);
        vec_t v = vi;
        v.acdb = 1'b1; v.atag = tag; v.ares = res;
        return v;
    endfunction

    function automatic vec_t w_lcdb(input vec_t vi, input logic [3:0] tag, input logic [31:0] res);
        vec_t v = vi;
        v.lcdb = 1'b1; v.ltag = tag; v.lres = res;
        return v;
    endfunction

    function automatic vec_t w_exp(input vec_t vi, input logic [5:0] op, input logic [3:0] name,
                                   input logic [31:0] lhs, input logic [31:0] rhs);
        vec_t v = vi;
        v.e_sgn = 1'b1; v.e_op = op; v.e_name = name; v.e_lhs = lhs; v.e_rhs = rhs;
        return v;
    endfunction

    function automatic vec_t w_stall(input vec_t vi);
        vec_t v = vi;
        v.rdy = 1'b0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rdy                  = v.rdy;
        clr                  = 1'b0;
        bus.DP_sgn           = v.dp;
        bus.DP_opcode        = v.op;
        bus.DP_ROB_name      = v.name;
        bus.DP_Qj_sgn        = v.qjs;
        bus.DP_Qj            = v.qj;
        bus.DP_Vj            = v.vj;
        bus.DP_Qk_sgn        = v.qks;
        bus.DP_Qk            = v.qk;
        bus.DP_Vk            = v.vk;
        bus.ALU_CDB_sgn      = v.acdb;
        bus.ALU_CDB_ROB_name = v.atag;
        bus.ALU_CDB_result   = v.ares;
        bus.LSB_CDB_sgn      = v.lcdb;
        bus.LSB_CDB_ROB_name = v.ltag;
        bus.LSB_CDB_result   = v.lres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string nm, input vec_t v);
        check({nm, " sgn"}, 32'(bus.ALU_sgn), 32'(v.e_sgn));
        if (v.e_sgn) begin
            check({nm, " op"},   32'(bus.ALU_opcode),   32'(v.e_op));
            check({nm, " name"}, 32'(bus.ALU_ROB_name), 32'(v.e_name));
            check({nm, " lhs"},  bus.ALU_lhs,           v.e_lhs);
            check({nm, " rhs"},  bus.ALU_rhs,           v.e_rhs);
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;

        rst = 1'b0;
        drive(v_idle());
        step();
        step();
        check("reset sgn",   32'(bus.ALU_sgn), 32'h0);
        check("reset op",    32'(bus.ALU_opcode), 32'h0);
        check("reset name",  32'(bus.ALU_ROB_name), 32'h0);
        check("reset lhs",   bus.ALU_lhs, 32'h0);
        check("reset rhs",   bus.ALU_rhs, 32'h0);
        check("reset full",  32'(bus.RS_full), 32'h0);
        rst = 1'b1;

        // Ready op: issue one cycle after dispatch, for one cycle only.
        vecs.push_back(v_dp(OP_ADDI, 4'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd3));
        vecs.push_back(w_exp(v_idle(), OP_ADDI, 4'd5, 32'd7, 32'd3));
        vecs.push_back(v_idle());
        // Pending Qj woken by ALU CDB.
        vecs.push_back(v_dp(OP_SUB, 4'd2, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1));
        vecs.push_back(v_idle());
        v = w_acdb(v_idle(), 4'd9, 32'd40);
        vecs.push_back(FAST ? w_exp(v, OP_SUB, 4'd2, 32'd40, 32'd1) : v);
        vecs.push_back(FAST ? v_idle() : w_exp(v_idle(), OP_SUB, 4'd2, 32'd40, 32'd1));
        // Qk captured from same-cycle LSB CDB at dispatch.
        vecs.push_back(w_lcdb(v_dp(OP_ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b1, 4'd7, 32'd0), 4'd7, 32'hDEAD));
        vecs.push_back(w_exp(v_idle(), OP_ADD, 4'd3, 32'd5, 32'hDEAD));
        vecs.push_back(v_idle());
        // Both buses wake different operands of one entry.
        vecs.push_back(v_dp(OP_XOR, 4'd4, 1'b1, 4'd10, 32'd0, 1'b1, 4'd11, 32'd0));
        v = w_lcdb(w_acdb(v_idle(), 4'd10, 32'h100), 4'd11, 32'h22);
        vecs.push_back(FAST ? w_exp(v, OP_XOR, 4'd4, 32'h100, 32'h22) : v);
        vecs.push_back(FAST ? v_idle() : w_exp(v_idle(), OP_XOR, 4'd4, 32'h100, 32'h22));
        // Two entries woken together: lower index issues first.
        vecs.push_back(v_dp(OP_OR,  4'd6, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd1));
        vecs.push_back(v_dp(OP_AND, 4'd7, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd2));
        v = w_acdb(v_idle(), 4'd12, 32'h55);
        vecs.push_back(FAST ? w_exp(v, OP_OR, 4'd6, 32'h55, 32'd1) : v);
        vecs.push_back(FAST ? w_exp(v_idle(), OP_AND, 4'd7, 32'h55, 32'd2)
                            : w_exp(v_idle(), OP_OR,  4'd6, 32'h55, 32'd1));
        vecs.push_back(FAST ? v_idle() : w_exp(v_idle(), OP_AND, 4'd7, 32'h55, 32'd2));
        vecs.push_back(v_idle());
        // Stall: dispatch ignored; ready entry frozen until rdy returns.
        vecs.push_back(w_stall(v_dp(OP_ADD, 4'd8, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2)));
        vecs.push_back(v_idle());
        vecs.push_back(v_dp(OP_ADD, 4'd9, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4));
        vecs.push_back(w_stall(v_idle()));
        vecs.push_back(w_exp(v_idle(), OP_ADD, 4'd9, 32'd3, 32'd4));
        vecs.push_back(v_idle());

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check_issue($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("vec%0d full", i), 32'(bus.RS_full), 32'h0);
        end

        // Fill RS_SIZE-1 pending entries; entry 0 waits on tag 14, the rest on 13.
        for (int i = 0; i < 15; i++) begin
            drive(v_dp(OP_ADD, 4'(i), 1'b1, (i == 0) ? 4'd14 : 4'd13, 32'd0, 1'b0, 4'd0, 32'(i)));
            step();
            if (i == 13) check("fill14 full", 32'(bus.RS_full), 32'h0);
        end
        check("fill15 full", 32'(bus.RS_full), 32'h1);
        check("fill15 sgn",  32'(bus.ALU_sgn), 32'h0);
        drive(w_acdb(v_idle(), 4'd14, 32'h77));
        step();
        if (FAST) begin
            check_issue("full wake", w_exp(v_idle(), OP_ADD, 4'd0, 32'h77, 32'd0));
            check("full wake full", 32'(bus.RS_full), 32'h0);
        end else begin
            check_issue("full wake", v_idle());
            check("full wake full", 32'(bus.RS_full), 32'h1);
        end
        drive(v_idle());
        step();
        check_issue("full drain", FAST ? v_idle() : w_exp(v_idle(), OP_ADD, 4'd0, 32'h77, 32'd0));
        check("full drain full", 32'(bus.RS_full), 32'h0);

        // Flush beats a simultaneous dispatch and a ready entry.
        drive(v_dp(OP_ADD, 4'd1, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22));
        step();
        drive(v_dp(OP_SUB, 4'd2, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44));
        clr = 1'b1;
        step();
        check("clr sgn",  32'(bus.ALU_sgn), 32'h0);
        check("clr full", 32'(bus.RS_full), 32'h0);
        drive(v_idle());
        step();
        check("clr after1 sgn", 32'(bus.ALU_sgn), 32'h0);
        step();
        check("clr after2 sgn", 32'(bus.ALU_sgn), 32'h0);
        for (int i = 0; i < 15; i++) begin
            drive(v_dp(OP_OR, 4'(i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0));
            step();
            if (i == 13) check("clr count14 full", 32'(bus.RS_full), 32'h0);
        end
        check("clr count15 full", 32'(bus.RS_full), 32'h1);
        drive(v_idle());
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr2 full", 32'(bus.RS_full), 32'h0);

        // Asynchronous reset mid-issue with three pending entries.
        for (int i = 0; i < 3; i++) begin
            drive(v_dp(OP_SUB, 4'(10 + i), 1'b1, 4'd8, 32'd0, 1'b0, 4'd0, 32'd5));
            step();
        end
        drive(v_dp(OP_ADD, 4'd13, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hB));
        step();
        drive(v_idle());
        step();
        check_issue("pre-rst", w_exp(v_idle(), OP_ADD, 4'd13, 32'hA, 32'hB));
        #2 rst = 1'b0;
        #1;
        check("async rst sgn",  32'(bus.ALU_sgn), 32'h0);
        check("async rst lhs",  bus.ALU_lhs, 32'h0);
        check("async rst full", 32'(bus.RS_full), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(w_acdb(v_idle(), 4'd8, 32'h1));
        step();
        check("post-rst wake sgn", 32'(bus.ALU_sgn), 32'h0);
        drive(v_idle());
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("post-rst idle%0d sgn", i), 32'(bus.ALU_sgn), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
